// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector: synchroniser, glitch filter, rise/fall strobes,
// sticky event flags with interrupt, and a saturating global event counter.
module multi_edge_detect #(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] rise_en_i,
    input  logic [WIDTH-1:0] fall_en_i,
    input  logic [WIDTH-1:0] clr_i,
    input  logic             cnt_clr_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rising_edge_o,
    output logic [WIDTH-1:0] falling_edge_o,
    output logic [WIDTH-1:0] sticky_o,
    output logic             irq_o,
    output logic [CNT_W-1:0] evt_count_o
);

    localparam int CW = $clog2(FILTER_CYCLES) + 1;
    localparam int NW = $clog2(2 * WIDTH + 1);
    localparam int SW = CNT_W + NW + 1;
    localparam logic [CW-1:0]    CTHR = CW'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [WIDTH-1:0] s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = a_i;
        end else begin : g_sync
            logic [WIDTH-1:0] sync_q [SYNC_STAGES];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
                end else begin
                    sync_q[0] <= a_i;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [WIDTH-1:0] level_q, level_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0] evt_q, evt_d;
    logic [NW-1:0]    n_evt;
    logic [SW-1:0]    sum;

    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CTHR) begin
                level_d[i] = s[i];
                cnt_d[i]   = '0;
                rise_d[i]  = s[i] & rise_en_i[i];
                fall_d[i]  = ~s[i] & fall_en_i[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_comb begin
        n_evt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n_evt = n_evt + NW'(rise_d[i]) + NW'(fall_d[i]);
        end
        // Sticky set has priority over clear so no event is ever lost
        sticky_d = (sticky_q & ~clr_i) | rise_d | fall_d;
        sum = (cnt_clr_i ? '0 : SW'(evt_q)) + SW'(n_evt);
        if (sum > SW'(CMAX)) evt_d = CMAX;
        else                 evt_d = sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q  <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            sticky_q <= '0;
            evt_q    <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sticky_q <= sticky_d;
            evt_q    <= evt_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign level_o        = level_q;
    assign rising_edge_o  = rise_q;
    assign falling_edge_o = fall_q;
    assign sticky_o       = sticky_q;
    assign irq_o          = |sticky_q;
    assign evt_count_o    = evt_q;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Directed bench for multi_edge_detect with default parameters.
module tb_multi_edge_detect;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] a, rise_en, fall_en, clr;
    logic       cnt_clr;
    logic [3:0] level, rising, falling, sticky;
    logic       irq;
    logic [7:0] cnt;

    int tests = 0;
    int fails = 0;

    multi_edge_detect dut (
        .clk            (clk),
        .reset          (reset),
        .a_i            (a),
        .rise_en_i      (rise_en),
        .fall_en_i      (fall_en),
        .clr_i          (clr),
        .cnt_clr_i      (cnt_clr),
        .level_o        (level),
        .rising_edge_o  (rising),
        .falling_edge_o (falling),
        .sticky_o       (sticky),
        .irq_o          (irq),
        .evt_count_o    (cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; a = '0; rise_en = '1; fall_en = '1;
        clr = '0; cnt_clr = 1'b0;
        tick(2);
        reset = 1'b0;
        tests++;
        if ({level, rising, falling, sticky, irq, cnt} !== 25'd0) begin
            fails++;
            $display("FAIL reset_state got %h want 0",
                     {level, rising, falling, sticky, irq, cnt});
        end
    endtask

    task automatic test_rise;
        a = 4'b0001;
        tick(4);
        tests++;
        if (level !== 4'b0000 || rising !== 4'b0000) begin
            fails++;
            $display("FAIL rise_early level=%b rising=%b want 0", level, rising);
        end
        tick();
        tests++;
        if (rising !== 4'b0001 || level !== 4'b0001) begin
            fails++;
            $display("FAIL rise_pulse rising=%b level=%b want 0001", rising, level);
        end
        tests++;
        if (sticky !== 4'b0001 || irq !== 1'b1 || cnt !== 8'd1) begin
            fails++;
            $display("FAIL rise_flags sticky=%b irq=%b cnt=%0d want 0001/1/1",
                     sticky, irq, cnt);
        end
        tick();
        tests++;
        if (rising !== 4'b0000 || level !== 4'b0001) begin
            fails++;
            $display("FAIL rise_one_cycle rising=%b level=%b", rising, level);
        end
    endtask

    task automatic test_glitch;
        int rc = 0, fc = 0;
        fall_en = 4'b1101;
        a[1] = 1'b1;
        tick(2);
        a[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            rc += int'(rising[1]);
            fc += int'(falling[1]);
        end
        tests++;
        if (rc != 0 || level[1] !== 1'b0 || cnt !== 8'd1) begin
            fails++;
            $display("FAIL glitch_reject pulses=%0d level=%b cnt=%0d want 0/0/1",
                     rc, level[1], cnt);
        end
        a[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            rc += int'(rising[1]);
        end
        a[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            rc += int'(rising[1]);
            fc += int'(falling[1]);
        end
        tests++;
        if (rc != 1 || fc != 0 || cnt !== 8'd2 || level[1] !== 1'b0) begin
            fails++;
            $display("FAIL glitch_accept rise=%0d fall=%0d cnt=%0d lvl=%b want 1/0/2/0",
                     rc, fc, cnt, level[1]);
        end
        fall_en = 4'b1111;
    endtask

    task automatic test_disabled_fall;
        int rc = 0, fc = 0;
        fall_en = 4'b1110;
        a[0] = 1'b0;
        tick(4);
        tests++;
        if (level[0] !== 1'b1) begin
            fails++;
            $display("FAIL dis_fall_early level0=%b want 1", level[0]);
        end
        tick();
        tests++;
        if (level[0] !== 1'b0 || falling !== 4'b0000 ||
            sticky !== 4'b0011 || cnt !== 8'd2) begin
            fails++;
            $display("FAIL dis_fall lvl=%b fall=%b sticky=%b cnt=%0d want 0/0000/0011/2",
                     level[0], falling, sticky, cnt);
        end
        fall_en = 4'b1111;
        a[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            rc += int'(rising[0]);
            fc += int'(falling[0]);
        end
        a[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            rc += int'(rising[0]);
            fc += int'(falling[0]);
        end
        tests++;
        if (rc != 1 || fc != 1 || cnt !== 8'd4) begin
            fails++;
            $display("FAIL en_fall rise=%0d fall=%0d cnt=%0d want 1/1/4", rc, fc, cnt);
        end
    endtask

    task automatic test_saturate;
        for (int t = 0; t < 62; t++) begin
            a = ~a;
            tick(6);
        end
        a[1] = 1'b1;
        tick(6);
        a[1] = 1'b0;
        tick(6);
        tests++;
        if (cnt !== 8'd254 || level !== 4'b0000) begin
            fails++;
            $display("FAIL sat_prep cnt=%0d level=%b want 254/0000", cnt, level);
        end
        a = 4'b1101;
        tick(5);
        tests++;
        if (rising !== 4'b1101 || cnt !== 8'd255) begin
            fails++;
            $display("FAIL sat_multi rising=%b cnt=%0d want 1101/255", rising, cnt);
        end
        a[1] = 1'b1;
        tick(6);
        tests++;
        if (cnt !== 8'd255 || level !== 4'b1111) begin
            fails++;
            $display("FAIL sat_hold cnt=%0d level=%b want 255/1111", cnt, level);
        end
    endtask

    task automatic test_clear;
        a[0] = 1'b0;
        tick(4);
        clr = 4'b0001;
        tick();
        tests++;
        if (falling !== 4'b0001 || sticky[0] !== 1'b1) begin
            fails++;
            $display("FAIL clr_vs_set fall=%b sticky0=%b want 0001/1", falling, sticky[0]);
        end
        tick();
        tests++;
        if (sticky !== 4'b1110 || irq !== 1'b1) begin
            fails++;
            $display("FAIL clr_one sticky=%b irq=%b want 1110/1", sticky, irq);
        end
        clr = 4'b1111;
        tick();
        clr = 4'b0000;
        tests++;
        if (sticky !== 4'b0000 || irq !== 1'b0) begin
            fails++;
            $display("FAIL clr_all sticky=%b irq=%b want 0000/0", sticky, irq);
        end
        a = 4'b0010;
        tick(4);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        tests++;
        if (falling !== 4'b1100 || cnt !== 8'd2) begin
            fails++;
            $display("FAIL cnt_clr fall=%b cnt=%0d want 1100/2", falling, cnt);
        end
        tick();
        tests++;
        if (cnt !== 8'd2 || falling !== 4'b0000 || sticky !== 4'b1100) begin
            fails++;
            $display("FAIL cnt_clr_hold cnt=%0d fall=%b sticky=%b want 2/0000/1100",
                     cnt, falling, sticky);
        end
    endtask

    task automatic test_mid_reset;
        a = 4'b0100;
        tick(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if ({level, rising, falling, sticky, irq, cnt} !== 25'd0) begin
            fails++;
            $display("FAIL mid_reset got %h want 0",
                     {level, rising, falling, sticky, irq, cnt});
        end
        tick(4);
        tests++;
        if (rising !== 4'b0000 || level !== 4'b0000) begin
            fails++;
            $display("FAIL post_reset_early rising=%b level=%b want 0", rising, level);
        end
        tick();
        tests++;
        if (rising !== 4'b0100 || level !== 4'b0100 ||
            cnt !== 8'd1 || sticky !== 4'b0100) begin
            fails++;
            $display("FAIL post_reset_rise r=%b l=%b cnt=%0d s=%b want 0100/0100/1/0100",
                     rising, level, cnt, sticky);
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_glitch();
        test_disabled_fall();
        test_saturate();
        test_clear();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
